dram_writer_buf: RTL and testbench

DRAM_WRITER_BUF -- requirements
Module: dram_writer_buf

---
 rtl/dram_buf_pkg.sv | 22 ++
 rtl/dram_sync_fifo.sv | 54 +++++
 rtl/dram_writer_buf.sv | 158 +++++++++++++++
 tb/tb_dram_writer_buf.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_buf_pkg.sv
// Shared definitions for the DRAM frame writer and reader: FSM state encoding,
// AXI burst attribute constants and burst sizing.
package dram_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_SIZE_8B     = 2'b11;
  localparam int unsigned BEAT_BYTES      = 8;
  localparam int unsigned BURST_BEATS_DEF = 16;
  localparam int unsigned BURST_BYTES     = BURST_BEATS_DEF * BEAT_BYTES;

  function automatic logic [31:0] burst_bytes(input int unsigned beats);
    return 32'(beats * BEAT_BYTES);
  endfunction

endpackage

// File: rtl/dram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// The head word is visible on o_data whenever the FIFO is not empty.
module dram_sync_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage is not reset; emptying is done through the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/dram_writer_buf.sv
// Buffers a 64-bit pixel stream and writes frames to DRAM as fixed-length AXI INCR
// bursts, one burst outstanding at a time. Define DRAM_WRITER_BRESP_CHECK_EN for wr_error.
module dram_writer_buf
  import dram_buf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned BURST_BEATS = 16
) (
  input  logic        fclk,
  input  logic        rst_n,
  output logic        M2S_AXI_ACLK,
  output logic        M2S_AXI_AWVALID,
  input  logic        M2S_AXI_AWREADY,
  output logic [31:0] M2S_AXI_AWADDR,
  output logic [1:0]  M2S_AXI_AWBURST,
  output logic [3:0]  M2S_AXI_AWLEN,
  output logic [1:0]  M2S_AXI_AWSIZE,
  output logic        M2S_AXI_WVALID,
  input  logic        M2S_AXI_WREADY,
  output logic        M2S_AXI_WLAST,
  output logic [63:0] M2S_AXI_WDATA,
  output logic [7:0]  M2S_AXI_WSTRB,
  input  logic        M2S_AXI_BVALID,
  output logic        M2S_AXI_BREADY,
  input  logic [1:0]  M2S_AXI_BRESP,
  input  logic        wr_frame_valid,
  output logic        wr_frame_ready,
  input  logic [31:0] wr_BUF_ADDR,
  input  logic [31:0] wr_FRAME_BYTES,
  output logic        wr_frame_done,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din,
  output logic        wr_error,
  output logic [1:0]  debug_astate
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCW = $clog2(BURST_BEATS) + 1;
  localparam logic [31:0] LP_BURST_BYTES = burst_bytes(BURST_BEATS);

  wstate_e          r_state;
  logic [31:0]      r_awaddr;
  logic [31:0]      r_end;
  logic [BCW-1:0]   r_beat;
  logic             r_frame_ready;
  logic             r_frame_done;
  logic             r_error;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CW-1:0]    w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_aw_hs;
  logic [31:0]      w_next_addr;

  dram_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .i_clk   (fclk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (din),
    .i_pop   (w_pop),
    .o_data  (M2S_AXI_WDATA),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign M2S_AXI_ACLK    = fclk;
  assign M2S_AXI_AWBURST = AXI_BURST_INCR;
  assign M2S_AXI_AWLEN   = 4'(BURST_BEATS - 1);
  assign M2S_AXI_AWSIZE  = AXI_SIZE_8B;
  assign M2S_AXI_WSTRB   = 8'hFF;
  assign M2S_AXI_AWADDR  = r_awaddr;

  // A burst is only requested once its whole payload is buffered, so W never stalls on data.
  assign M2S_AXI_AWVALID = (r_state == W_ADDR) && (w_count >= CW'(BURST_BEATS));
  assign M2S_AXI_WVALID  = (r_state == W_DATA) && (r_beat < BCW'(BURST_BEATS)) && !w_fifo_empty;
  assign M2S_AXI_WLAST   = (r_state == W_DATA) && (r_beat == BCW'(BURST_BEATS - 1));
  assign M2S_AXI_BREADY  = (r_state == W_RESP);

  assign din_ready      = !w_fifo_full;
  assign w_push         = din_valid && din_ready;
  assign w_pop          = M2S_AXI_WVALID && M2S_AXI_WREADY;
  assign w_aw_hs        = M2S_AXI_AWVALID && M2S_AXI_AWREADY;
  assign w_next_addr    = r_awaddr + LP_BURST_BYTES;
  assign wr_frame_ready = r_frame_ready;
  assign wr_frame_done  = r_frame_done;
  assign wr_error       = r_error;
  assign debug_astate   = r_state;

`ifndef DRAM_WRITER_BRESP_CHECK_EN
  logic w_unused_bresp;
  assign w_unused_bresp = ^M2S_AXI_BRESP;
`endif

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      r_state       <= W_IDLE;
      r_awaddr      <= '0;
      r_end         <= '0;
      r_beat        <= '0;
      r_frame_ready <= 1'b0;
      r_frame_done  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        W_IDLE: begin
          r_frame_ready <= 1'b1;
          if (r_frame_ready && wr_frame_valid) begin
            r_awaddr <= wr_BUF_ADDR;
            r_end    <= wr_BUF_ADDR + wr_FRAME_BYTES;
            if (wr_FRAME_BYTES == '0) begin
              r_frame_done <= 1'b1;
            end else begin
              r_frame_ready <= 1'b0;
              r_state       <= W_ADDR;
            end
          end
        end
        W_ADDR: begin
          if (w_aw_hs) begin
            r_beat  <= '0;
            r_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_pop) begin
            r_beat <= r_beat + BCW'(1);
            if (r_beat == BCW'(BURST_BEATS - 1)) r_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (M2S_AXI_BVALID) begin
            r_awaddr <= w_next_addr;
`ifdef DRAM_WRITER_BRESP_CHECK_EN
            if (M2S_AXI_BRESP != 2'b00) r_error <= 1'b1;
`endif
            if (w_next_addr == r_end) begin
              r_frame_done  <= 1'b1;
              r_frame_ready <= 1'b1;
              r_state       <= W_IDLE;
            end else begin
              r_state <= W_ADDR;
            end
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_writer_buf.sv
// Randomized self-checking bench for dram_writer_buf against a queue-based frame model.
module tb_dram_writer_buf;

  localparam int DEPTH  = 512;
  localparam int BEATS  = 16;
  localparam int BBYTES = 128;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aclk, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr;
  logic [1:0]  awburst, awsize, bresp, astate;
  logic [3:0]  awlen;
  logic [63:0] wdata, din;
  logic [7:0]  wstrb;
  logic        fvalid, fready, fdone, din_valid, din_ready, werr;
  logic [31:0] fbase, fbytes;

  always #5 fclk = ~fclk;

  dram_writer_buf dut (
    .fclk(fclk), .rst_n(rst_n), .M2S_AXI_ACLK(aclk),
    .M2S_AXI_AWVALID(awvalid), .M2S_AXI_AWREADY(awready), .M2S_AXI_AWADDR(awaddr),
    .M2S_AXI_AWBURST(awburst), .M2S_AXI_AWLEN(awlen), .M2S_AXI_AWSIZE(awsize),
    .M2S_AXI_WVALID(wvalid), .M2S_AXI_WREADY(wready), .M2S_AXI_WLAST(wlast),
    .M2S_AXI_WDATA(wdata), .M2S_AXI_WSTRB(wstrb),
    .M2S_AXI_BVALID(bvalid), .M2S_AXI_BREADY(bready), .M2S_AXI_BRESP(bresp),
    .wr_frame_valid(fvalid), .wr_frame_ready(fready), .wr_BUF_ADDR(fbase),
    .wr_FRAME_BYTES(fbytes), .wr_frame_done(fdone),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .wr_error(werr), .debug_astate(astate)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: buffered words, protocol phase (0 idle,1 addr,2 data,3 resp), frame progress.
  logic [63:0] q_model[$];
  int          phase = 0;
  logic [31:0] m_addr, m_end;
  int          m_beat = 0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] aw_log[$];
  int          wlast_log[$];
  int          frame_beats = 0;

  task automatic idle_inputs();
    fvalid = 0; fbase = '0; fbytes = '0; awready = 0; wready = 0;
    bvalid = 0; bresp = 2'b00; din_valid = 0; din = '0;
  endtask

  // One cycle: compare every output with the model, then advance the model.
  task automatic step();
    logic exp_aw, push;
    logic [63:0] exp_w;
    int p;
    p = phase;
    exp_aw = (p == 1) && (q_model.size() >= BEATS);
    push = din_valid && (q_model.size() < DEPTH);
    n_cmp++;
    if (awvalid !== exp_aw) begin
      n_bad++; $display("FAIL awvalid t=%0t got %b want %b", $time, awvalid, exp_aw);
    end
    if (exp_aw) begin
      n_cmp++;
      if (awaddr !== m_addr) begin
        n_bad++; $display("FAIL awaddr t=%0t got %h want %h", $time, awaddr, m_addr);
      end
    end
    n_cmp++;
    if (wvalid !== (p == 2)) begin
      n_bad++; $display("FAIL wvalid t=%0t got %b want %b", $time, wvalid, p == 2);
    end
    if (p == 2) begin
      n_cmp++;
      if (wlast !== (m_beat == BEATS - 1)) begin
        n_bad++; $display("FAIL wlast t=%0t got %b beat %0d", $time, wlast, m_beat);
      end
    end
    n_cmp++;
    if (bready !== (p == 3)) begin
      n_bad++; $display("FAIL bready t=%0t got %b want %b", $time, bready, p == 3);
    end
    n_cmp++;
    if (fready !== (p == 0)) begin
      n_bad++; $display("FAIL frame_ready t=%0t got %b want %b", $time, fready, p == 0);
    end
    n_cmp++;
    if (fdone !== m_done) begin
      n_bad++; $display("FAIL frame_done t=%0t got %b want %b", $time, fdone, m_done);
    end
    n_cmp++;
    if (din_ready !== (q_model.size() < DEPTH)) begin
      n_bad++; $display("FAIL din_ready t=%0t got %b want %b (words %0d)", $time, din_ready,
                        q_model.size() < DEPTH, q_model.size());
    end
    n_cmp++;
    if (werr !== m_err) begin
      n_bad++; $display("FAIL wr_error t=%0t got %b want %b", $time, werr, m_err);
    end
    n_cmp++;
    if (astate !== 2'(p)) begin
      n_bad++; $display("FAIL astate t=%0t got %0d want %0d", $time, astate, p);
    end

    m_done = 1'b0;
    case (p)
      0: if (fvalid) begin
        m_addr = fbase;
        m_end  = fbase + fbytes;
        if (fbytes == 0) m_done = 1'b1;
        else phase = 1;
      end
      1: if (exp_aw && awready) begin
        aw_log.push_back(m_addr);
        m_beat = 0;
        phase = 2;
      end
      2: if (wready) begin
        exp_w = (q_model.size() > 0) ? q_model.pop_front() : 64'hx;
        n_cmp++;
        if (wdata !== exp_w) begin
          n_bad++; $display("FAIL wdata t=%0t got %h want %h", $time, wdata, exp_w);
        end
        if (m_beat == BEATS - 1) wlast_log.push_back(frame_beats);
        frame_beats++;
        m_beat++;
        if (m_beat == BEATS) phase = 3;
      end
      3: if (bvalid) begin
        m_addr = m_addr + BBYTES;
`ifdef DRAM_WRITER_BRESP_CHECK_EN
        if (bresp != 2'b00) m_err = 1'b1;
`endif
        if (m_addr == m_end) begin
          m_done = 1'b1;
          phase = 0;
        end else begin
          phase = 1;
        end
      end
      default: ;
    endcase
    if (push) q_model.push_back(din);
    @(negedge fclk);
  endtask

  task automatic preload(input int n);
    idle_inputs();
    while (q_model.size() < n) begin
      din_valid = 1; din = {$urandom, $urandom};
      step();
    end
    din_valid = 0;
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [31:0] bytes);
    idle_inputs();
    aw_log.delete(); wlast_log.delete(); frame_beats = 0;
    fvalid = 1; fbase = base; fbytes = bytes;
    step();
    fvalid = 0;
  endtask

  task automatic run_traffic(input int aw_pct, input int w_pct, input int b_pct,
                             input int din_pct, input int pushes, input logic [1:0] rsp,
                             input int budget);
    int cyc = 0;
    int left = pushes;
    logic pushed;
    while (phase != 0 && cyc < budget) begin
      awready = ($urandom_range(99) < aw_pct);
      wready  = ($urandom_range(99) < w_pct);
      bvalid  = (phase == 3) && ($urandom_range(99) < b_pct);
      bresp   = rsp;
      din_valid = (left > 0) && ($urandom_range(99) < din_pct);
      din = {$urandom, $urandom};
      pushed = din_valid && (q_model.size() < DEPTH);
      step();
      if (pushed) left--;
      cyc++;
    end
    n_cmp++;
    if (phase != 0) begin
      n_bad++; $display("FAIL frame_timeout phase %0d after %0d cycles", phase, cyc);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge fclk);
    n_cmp++;
    if ({awvalid, wvalid, wlast, bready, fready, fdone, werr} !== 7'b0 || astate !== 2'd0) begin
      n_bad++; $display("FAIL reset_ctrl got %b%b%b%b%b%b%b st %0d want 0", awvalid, wvalid,
                        wlast, bready, fready, fdone, werr, astate);
    end
    n_cmp++;
    if (awaddr !== 32'h0 || din_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_addr got %h/%b want 0/1", awaddr, din_ready);
    end
    n_cmp++;
    if (awburst !== 2'b01 || awlen !== 4'd15 || awsize !== 2'b11 || wstrb !== 8'hFF) begin
      n_bad++; $display("FAIL axi_consts got %b %0d %b %h", awburst, awlen, awsize, wstrb);
    end
    n_cmp++;
    if (aclk !== fclk) begin
      n_bad++; $display("FAIL aclk got %b want %b", aclk, fclk);
    end
    rst_n = 1;
    q_model.delete(); phase = 0; m_done = 0; m_err = 0;
    @(negedge fclk);
    step();
  endtask

  task automatic test_basic();
    preload(32);
    start_frame(32'h1000_0000, 32'd256);
    run_traffic(100, 100, 100, 0, 0, 2'b00, 200);
    n_cmp++;
    if (aw_log.size() != 2 || aw_log[0] !== 32'h1000_0000 || aw_log[1] !== 32'h1000_0080) begin
      n_bad++; $display("FAIL basic_aw got %0d bursts first %h want 2 at 10000000/10000080",
                        aw_log.size(), aw_log.size() > 0 ? aw_log[0] : 32'hx);
    end
    n_cmp++;
    if (wlast_log.size() != 2 || wlast_log[0] != 15 || wlast_log[1] != 31) begin
      n_bad++; $display("FAIL basic_wlast got %0d lasts want beats 15,31", wlast_log.size());
    end
  endtask

  task automatic test_zero_bytes();
    start_frame(32'h2000_0000, 32'd0);
    step();
    step();
  endtask

  task automatic test_threshold();
    int base_words;
    base_words = q_model.size();
    start_frame(32'h2000_0000, 32'd128);
    repeat (15 - base_words) begin
      din_valid = 1; din = {$urandom, $urandom};
      step();
    end
    din_valid = 0;
    repeat (3) step();
    n_cmp++;
    if (awvalid !== 1'b0) begin
      n_bad++; $display("FAIL threshold_15 got awvalid %b want 0", awvalid);
    end
    din_valid = 1; din = {$urandom, $urandom};
    step();
    din_valid = 0;
    n_cmp++;
    if (awvalid !== 1'b1) begin
      n_bad++; $display("FAIL threshold_16 got awvalid %b want 1", awvalid);
    end
    run_traffic(100, 50, 100, 0, 0, 2'b00, 300);
  endtask

  task automatic test_aw_stall();
    preload(16);
    start_frame(32'h3000_0100, 32'd128);
    repeat (5) step();
    run_traffic(100, 50, 60, 0, 0, 2'b00, 300);
    n_cmp++;
    if (frame_beats != 16) begin
      n_bad++; $display("FAIL stall_pops got %0d want 16", frame_beats);
    end
  endtask

  task automatic test_fifo_full();
    int bursts;
    preload(DEPTH);
    din_valid = 1; din = {$urandom, $urandom};
    step();
    din_valid = 0;
    start_frame(32'h4000_0000, 32'd256);
    run_traffic(100, 100, 100, 100, 50, 2'b00, 300);
    bursts = q_model.size() / BEATS;
    start_frame(32'hFFFF_F000, 32'(bursts * BBYTES));
    run_traffic(100, 100, 100, 0, 0, 2'b00, 2000);
    n_cmp++;
    if (frame_beats != bursts * BEATS) begin
      n_bad++; $display("FAIL drain_pops got %0d want %0d", frame_beats, bursts * BEATS);
    end
  endtask

  task automatic test_bresp();
    logic exp;
    preload(32);
    start_frame(32'h5000_0000, 32'd256);
    run_traffic(100, 100, 100, 0, 0, 2'b10, 200);
    preload(16);
    start_frame(32'h5000_1000, 32'd128);
    run_traffic(100, 100, 100, 0, 0, 2'b00, 200);
`ifdef DRAM_WRITER_BRESP_CHECK_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    n_cmp++;
    if (werr !== exp) begin
      n_bad++; $display("FAIL bresp_sticky got %b want %b", werr, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, base;
    int k;
    for (int i = 0; i < 7; i++) begin
      r = $urandom;
      base = (i == 0) ? 32'hFFFF_FF80 : {r[31:7], 7'b0};
      k = (i == 0) ? 2 : $urandom_range(1, 3);
      start_frame(base, 32'(k * BBYTES));
      run_traffic($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                  $urandom_range(40, 100), k * BEATS + 5, 2'b00, 1500);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    preload(16);
    start_frame(32'h6000_0000, 32'd128);
    awready = 1; wready = 1;
    while (!(phase == 2 && m_beat == 7) && cyc < 100) begin
      step();
      cyc++;
    end
    rst_n = 0;
    @(negedge fclk);
    n_cmp++;
    if (wvalid !== 1'b0 || astate !== 2'd0 || fready !== 1'b0 || awaddr !== 32'h0) begin
      n_bad++; $display("FAIL midreset got wv %b st %0d rdy %b addr %h want 0", wvalid, astate,
                        fready, awaddr);
    end
    idle_inputs();
    rst_n = 1;
    q_model.delete(); phase = 0; m_done = 0; m_err = 0;
    @(negedge fclk);
    n_cmp++;
    if (fready !== 1'b1 || din_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_release got rdy %b din_ready %b want 1/1", fready, din_ready);
    end
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_zero_bytes();
    test_threshold();
    test_aw_stall();
    test_fifo_full();
    test_bresp();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
